instruction_cache: RTL
======================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the pipeline IF port (readM1/address1/data1)
//  and a multi-cycle line-fill memory. Hits return the instruction combinationally in the same cycle.
//  A miss stalls IF via cpu_ready=0 while one line fill runs; the pipeline retries the same PC afterwards.
// PARAMETERS
//  WORD_SIZE   16  instruction/address width (`WORD_SIZE)
//  LINE_WORDS  4   words per line (power of 2); OFF_BITS=log2(LINE_WORDS)
//  NUM_LINES   4   lines (power of 2); IDX_BITS=log2(NUM_LINES); TAG = addr[15:OFF_BITS+IDX_BITS]
// PORTS
//  clk           in   1                    clock, all state on posedge
//  reset_n       in   1                    asynchronous active-low reset
//  cpu_read      in   1                    fetch request (datapath readM1)
//  cpu_addr      in   WORD_SIZE            fetch address (datapath address1 = PC)
//  cpu_data      out  WORD_SIZE            instruction; `NOP when cpu_ready=0
//  cpu_ready     out  1                    hit this cycle; datapath stalls IF/PC when 0 with cpu_read=1
//  invalidate    in   1                    clear all valid bits
//  mem_read      out  1                    line fill request, high throughout FILL
//  mem_addr      out  WORD_SIZE            line-aligned fill address (offset bits 0), stable in FILL
//  mem_data      in   LINE_WORDS*WORD_SIZE fill line; word k at bits [16k+15:16k]
//  mem_valid     in   1                    mem_data valid; single-cycle pulse
//  hit_count     out  WORD_SIZE            hit cycles, saturating
//  miss_count    out  WORD_SIZE            misses (IDLE->FILL transitions), saturating
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all valid=0, pend_inv=0, counters=0, mem_read=0, mem_addr=0;
//   outputs cpu_ready=0, cpu_data=`NOP. Data/tag arrays not reset.
//  States IDLE, FILL (one-hot or 1-bit, constants in cache_defs.v).
//  IDLE: hit = cpu_read & valid[idx] & tag[idx]==cpu_addr tag & !invalidate.
//   hit -> cpu_ready=1, cpu_data=line[idx][off], hit_count+1. Zero latency.
//   cpu_read & !hit & !invalidate -> latch {tag,idx}, mem_addr=cpu_addr with offset cleared,
//    miss_count+1, next=FILL.
//   invalidate -> all valid=0 at edge, cpu_ready=0 that cycle, no miss started.
//   cpu_read=0 -> no action, cpu_ready=0.
//  FILL: mem_read=1, mem_addr held, cpu_ready=0, cpu_addr ignored (redirect mid-fill allowed;
//   latched line still completes). On mem_valid: write mem_data, tag into latched idx;
//   valid=!(pend_inv|invalidate); if pend_inv|invalidate also clear all other valids; pend_inv=0; next=IDLE.
//   invalidate in FILL without mem_valid sets sticky pend_inv.
//  Miss penalty: memory latency L (mem_read rise to mem_valid, in cycles, L>=1) => L+1 cycles
//   with cpu_ready=0; first hit the cycle after the mem_valid edge.
//  mem_valid in IDLE ignored (e.g. late response after reset). No cache writes; no writeback.
//  Counters saturate at 16'hFFFF; never wrap.
//  Simultaneous hit+invalidate: invalidate wins (miss-free bubble).
// STRUCTURE
//  cache_defs.v (shared header, alongside opcodes.v): state encodings, default LINE_WORDS/NUM_LINES,
//   field-width macros OFF_BITS, IDX_BITS, TAG_BITS.
//  One sub-module: icache_line_array: tag/valid/data storage; comb read port by idx,
//   write port (idx, tag, line, valid), clear_all; async reset of valid only.
//  Top: FSM, miss latch, counters, hit compare, word select.
// TESTING (memory model, L=3, defaults)
//  Cold read 0x0010 -> cpu_ready=0 4 cycles, mem_read=1 with mem_addr=0x0010; then cpu_data=mem word0, miss_count=1.
//  After fill, fetch 0x0010..0x0013 back-to-back -> cpu_ready=1 each cycle, hit_count=4, no mem_read.
//  Fetch 0x0010,0x0050,0x0010 (same idx 0, tags 0x001/0x005) -> three misses, miss_count=3.
//  invalidate pulsed 1 cycle mid-FILL of 0x0020 -> fill completes, retry of 0x0020 misses again.
//  reset_n low mid-FILL, mem_valid pulsed after release -> stays IDLE, all lines invalid, counters 0.
//  Redirect cpu_addr 0x0030->0x0040 mid-FILL -> 0x0030 line filled, then 0x0040 misses; mem_addr stable in each FILL.

Source files
------------

// File: rtl/instruction_cache_pkg.sv
// instruction_cache_pkg: shared geometry, state encoding and helpers for the instruction cache
package instruction_cache_pkg;
  localparam int WORD_SIZE = 16;
  localparam int LINE_WORDS = 4;
  localparam int NUM_LINES = 4;
  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = WORD_SIZE - OFF_BITS - IDX_BITS;
  localparam int LINE_BITS = LINE_WORDS * WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] NOP = 16'hB1C0;
  typedef enum logic {IDLE, FILL} state_t;
  function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/instruction_cache_if.sv
// instruction_cache_if: fetch port and line-fill memory port of the instruction cache
interface instruction_cache_if;
  import instruction_cache_pkg::*;
  logic cpu_read;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_data;
  logic cpu_ready;
  logic invalidate;
  logic mem_read;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [LINE_BITS-1:0] mem_data;
  logic mem_valid;
  modport master(
    output cpu_read, cpu_addr, invalidate, mem_data, mem_valid,
    input cpu_data, cpu_ready, mem_read, mem_addr
  );
  modport slave(
    input cpu_read, cpu_addr, invalidate, mem_data, mem_valid,
    output cpu_data, cpu_ready, mem_read, mem_addr
  );
endinterface

// File: rtl/instruction_cache_line_array.sv
// instruction_cache_line_array: tag/valid/data storage with a combinational read port
module instruction_cache_line_array
  import instruction_cache_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic rd_valid,
  output logic [TAG_BITS-1:0] rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic we,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic wr_valid,
  input  logic clear_all
);
  logic [NUM_LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [NUM_LINES];
  logic [LINE_BITS-1:0] lines [NUM_LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_line = lines[rd_idx];
  // valid bits: clear_all first, a same-cycle line write then sets its own bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid <= '0;
    else begin
      if (clear_all) valid <= '0;
      if (we) valid[wr_idx] <= wr_valid;
    end
  end
  // tag and data storage, unreset
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      lines[wr_idx] <= wr_line;
    end
  end
endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only instruction cache with single-line fill on miss
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  instruction_cache_if.slave bus,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);
  state_t state, state_nx;
  logic [IDX_BITS-1:0] idx;
  logic [OFF_BITS-1:0] off;
  logic [TAG_BITS-1:0] tag;
  logic rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic hit, miss, fill_done, pend_inv;
  assign off = bus.cpu_addr[OFF_BITS-1:0];
  assign idx = bus.cpu_addr[OFF_BITS+:IDX_BITS];
  assign tag = bus.cpu_addr[WORD_SIZE-1-:TAG_BITS];
  assign hit = state == IDLE && bus.cpu_read && rd_valid && rd_tag == tag && !bus.invalidate;
  assign miss = state == IDLE && bus.cpu_read && !hit && !bus.invalidate;
  assign fill_done = state == FILL && bus.mem_valid;
  instruction_cache_line_array u_array (
    .clk(clk),
    .reset_n(reset_n),
    .rd_idx(idx),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_line(rd_line),
    .we(fill_done),
    .wr_idx(bus.mem_addr[OFF_BITS+:IDX_BITS]),
    .wr_tag(bus.mem_addr[WORD_SIZE-1-:TAG_BITS]),
    .wr_line(bus.mem_data),
    .wr_valid(!(pend_inv || bus.invalidate)),
    .clear_all(bus.invalidate || (fill_done && pend_inv))
  );
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: a miss starts a fill, the memory response ends it
  always_comb state_nx = state == IDLE ? (miss ? FILL : IDLE) : (bus.mem_valid ? IDLE : FILL);
  // outputs: zero-latency hit path, fill request while filling
  always_comb begin
    bus.cpu_ready = hit;
    bus.cpu_data = hit ? rd_line[WORD_SIZE*off+:WORD_SIZE] : NOP;
    bus.mem_read = state == FILL;
  end
  // miss latch doubles as the fill address; invalidate during a fill is remembered until it lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_addr <= '0;
      pend_inv <= 1'b0;
    end else begin
      if (miss) bus.mem_addr <= {bus.cpu_addr[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
      pend_inv <= state == FILL && !bus.mem_valid && (pend_inv || bus.invalidate);
    end
  end
  // saturating hit and miss counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      hit_count <= hit ? sat_inc(hit_count) : hit_count;
      miss_count <= miss ? sat_inc(miss_count) : miss_count;
    end
  end
endmodule
